gp_register_bank: RTL and testbench
===================================

// Module: gp_register_bank
// PURPOSE
//  Parametrised general-purpose register bank for the SAP-2 datapath; next generation of the single B register.
//  Holds NREGS registers of WIDTH bits (default B, C) with bus load, tri-state bus drive, in-place INR/DCR and Z/S flag generation.
//  Sits between the W bus and the ALU; oData feeds the ALU operand mux, wBus is the shared W bus.
// PARAMETERS
//  WIDTH   8  bits per register and bus width
//  NREGS   2  number of registers (index 0 = B, 1 = C)
//  SELW    1  select width, = max(1,$clog2(NREGS)); derived, do not override
// PORTS
//  iClk     in   1      clock, all state updates on rising edge
//  iRst_n   in   1      asynchronous active-low reset
//  iData    in   WIDTH  load data (driven from W bus)
//  iWrSel   in   SELW   target register for iLoad/iInc/iDec
//  iLoad    in   1      load iData into reg[iWrSel]
//  iInc     in   1      reg[iWrSel] <= reg[iWrSel] + 1 (INR)
//  iDec     in   1      reg[iWrSel] <= reg[iWrSel] - 1 (DCR)
//  iRdSel   in   SELW   register presented on oData / wBus
//  iEn      in   1      drive reg[iRdSel] onto wBus
//  oData    out  WIDTH  reg[iRdSel], combinational read of registered state
//  oZero    out  1      registered Z flag from last INR/DCR
//  oSign    out  1      registered S flag (MSB) from last INR/DCR
//  oErr     out  1      registered: illegal command in previous cycle
//  wBus     out  WIDTH  tri; reg[iRdSel] when iEn=1, else Z on every bit
// BEHAVIOUR
//  - Reset (iRst_n=0, async): all registers 0, oZero=0, oSign=0, oErr=0; wBus follows iEn immediately.
//  - Command priority per edge: iLoad > (iInc xor iDec) > hold. One register written per cycle max.
//  - iLoad with iInc or iDec: load wins, oErr <= 1.
//  - iInc and iDec together, no iLoad: register holds, flags hold, oErr <= 1.
//  - iWrSel >= NREGS (non-power-of-2 NREGS): no write, flags hold, oErr <= 1.
//  - oErr <= 0 on any other edge (legal command or idle); one-cycle sticky, not latched.
//  - INR/DCR modulo 2^WIDTH: 0xFF+1 -> 0x00, 0x00-1 -> 0xFF (WIDTH=8); no carry output.
//  - Flags update only on a successful INR/DCR edge: oZero = (result==0), oSign = result[WIDTH-1].
//    Load does NOT touch flags (SAP-2 MOV/MVI semantics).
//  - Latency: write visible on oData/wBus one cycle after the edge; flags valid same cycle as new value.
//  - Read-during-write with iRdSel==iWrSel: oData shows the old value until the edge (no bypass).
//  - iRdSel >= NREGS: oData = 0; wBus driven to 0 if iEn=1.
//  - Reset mid-operation overrides any pending command; no partial update.
// STRUCTURE
//  - Shared package sap2_pkg: SAP2_WIDTH=8, register index constants REG_B=0, REG_C=1.
//  - Sub-module gp_reg_cell: one WIDTH register with async reset, load/inc/dec, priority logic;
//    outputs next value for flag computation. Bank generates NREGS cells, write-decodes iWrSel,
//    read-muxes iRdSel, holds flag/err flops and WIDTH bufif1 drivers.
// TESTING
//  1 Reset: iRst_n=0 mid-cycle with iLoad=1 -> regs, oZero, oSign, oErr all 0 at once; iEn=0 -> wBus=ZZ.
//  2 Load/drive: load 0x3C to B, 0xA5 to C; iRdSel=1, iEn=1 -> wBus=0xA5; iEn=0 -> wBus=ZZ; flags unchanged (0,0).
//  3 Wrap: C=0xFF, INR C -> 0x00, oZero=1, oSign=0; DCR C -> 0xFF, oZero=0, oSign=1.
//  4 Conflicts: iInc=iDec=1 on B=0x10 -> B=0x10, oErr=1 next cycle, 0 after;
//    iLoad+iInc with iData=0x77 -> B=0x77, oErr=1, flags held.
//  5 Read-during-write: iRdSel=iWrSel=0, load 0x55 over 0x3C -> oData 0x3C before edge, 0x55 after.
//  6 NREGS=3, WIDTH=4: iWrSel=3 load -> no change, oErr=1; iRdSel=3 -> oData=0x0.

Source files
------------

// File: rtl/sap2_pkg.sv
// Shared SAP-2 datapath definitions: widths, register indices and the
// command decode used by the general-purpose register bank.
package sap2_pkg;

    localparam int SAP2_WIDTH = 8;
    localparam int REG_B      = 0;
    localparam int REG_C      = 1;

    // Per-cell operation after priority resolution
    typedef enum logic [1:0] {
        CMD_HOLD = 2'd0,
        CMD_LOAD = 2'd1,
        CMD_INC  = 2'd2,
        CMD_DEC  = 2'd3
    } cell_cmd_e;

    // Load beats INR/DCR; INR and DCR together cancel to a hold.
    function automatic cell_cmd_e decode_cmd(input logic load, input logic inc, input logic dec);
        cell_cmd_e cmd;
        if (load) begin
            cmd = CMD_LOAD;
        end else if (inc && !dec) begin
            cmd = CMD_INC;
        end else if (dec && !inc) begin
            cmd = CMD_DEC;
        end else begin
            cmd = CMD_HOLD;
        end
        return cmd;
    endfunction

    // True when more than one command strobe is raised in the same cycle.
    function automatic logic cmd_conflict(input logic load, input logic inc, input logic dec);
        return (load & (inc | dec)) | (inc & dec);
    endfunction

endpackage

// File: rtl/gp_reg_cell.sv
// One WIDTH-bit register of the bank. Computes its candidate next value for
// the resolved command (also exported so the bank can derive Z/S flags) and
// commits it only when write-enabled.
module gp_reg_cell
    import sap2_pkg::*;
#(
    parameter int WIDTH = SAP2_WIDTH
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  cell_cmd_e        iCmd,
    input  logic             iWe,
    input  logic [WIDTH-1:0] iData,
    output logic [WIDTH-1:0] oQ,
    output logic [WIDTH-1:0] oNext
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] next_s;

    // Candidate next value; arithmetic wraps modulo 2^WIDTH with no carry out
    always_comb begin
        next_s = q_r;
        case (iCmd)
            CMD_LOAD: next_s = iData;
            CMD_INC:  next_s = q_r + ONE;
            CMD_DEC:  next_s = q_r - ONE;
            CMD_HOLD: next_s = q_r;
            default:  next_s = q_r;
        endcase
    end

    // Register storage, cleared asynchronously, updated only when selected
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            q_r <= {WIDTH{1'b0}};
        end else if (iWe) begin
            q_r <= next_s;
        end else begin
            q_r <= q_r;
        end
    end

    assign oQ    = q_r;
    assign oNext = next_s;

endmodule

// File: rtl/gp_register_bank.sv
// General-purpose register bank for the SAP-2 datapath (B, C, ...).
// Bus load, in-place INR/DCR with registered Z/S flags, one-cycle error
// strobe for illegal commands, combinational read port and tri-state W bus.
module gp_register_bank
    import sap2_pkg::*;
#(
    parameter int WIDTH = SAP2_WIDTH,
    parameter int NREGS = 2,
    parameter int SELW  = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic [WIDTH-1:0] iData,
    input  logic [SELW-1:0]  iWrSel,
    input  logic             iLoad,
    input  logic             iInc,
    input  logic             iDec,
    input  logic [SELW-1:0]  iRdSel,
    input  logic             iEn,
    output logic [WIDTH-1:0] oData,
    output logic             oZero,
    output logic             oSign,
    output logic             oErr,
    output tri   [WIDTH-1:0] wBus
);

    cell_cmd_e        cmd_s;
    logic             sel_ok_s;
    logic             active_s;
    logic             err_s;
    logic             flag_upd_s;
    logic [NREGS-1:0] we_s;
    logic [WIDTH-1:0] q_s    [NREGS];
    logic [WIDTH-1:0] next_s [NREGS];
    logic [WIDTH-1:0] wr_next_s;
    logic [WIDTH-1:0] rd_s;
    logic             zero_r;
    logic             sign_r;
    logic             err_r;

    assign cmd_s      = decode_cmd(iLoad, iInc, iDec);
    // Extra bit keeps the compare meaningful when NREGS is a power of two
    assign sel_ok_s   = ({1'b0, iWrSel} < (SELW + 1)'(NREGS));
    assign active_s   = iLoad | iInc | iDec;
    assign err_s      = cmd_conflict(iLoad, iInc, iDec) | (active_s & ~sel_ok_s);
    assign flag_upd_s = sel_ok_s & ((cmd_s == CMD_INC) || (cmd_s == CMD_DEC));

    for (genvar g = 0; g < NREGS; g++) begin : g_cell
        assign we_s[g] = sel_ok_s & (cmd_s != CMD_HOLD) & (iWrSel == SELW'(g));

        gp_reg_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .iClk   (iClk),
            .iRst_n (iRst_n),
            .iCmd   (cmd_s),
            .iWe    (we_s[g]),
            .iData  (iData),
            .oQ     (q_s[g]),
            .oNext  (next_s[g])
        );
    end

    // Next value of the write target, used only for flag generation
    always_comb begin
        wr_next_s = {WIDTH{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            wr_next_s = wr_next_s | ({WIDTH{iWrSel == SELW'(i)}} & next_s[i]);
        end
    end

    // Read mux; an index with no register behind it reads as zero
    always_comb begin
        rd_s = {WIDTH{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            rd_s = rd_s | ({WIDTH{iRdSel == SELW'(i)}} & q_s[i]);
        end
    end

    // Flags follow successful INR/DCR only; error strobe lasts one cycle
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            zero_r <= 1'b0;
            sign_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            err_r <= err_s;
            if (flag_upd_s) begin
                zero_r <= (wr_next_s == {WIDTH{1'b0}});
                sign_r <= wr_next_s[WIDTH-1];
            end else begin
                zero_r <= zero_r;
                sign_r <= sign_r;
            end
        end
    end

    assign oData = rd_s;
    assign oZero = zero_r;
    assign oSign = sign_r;
    assign oErr  = err_r;

    for (genvar b = 0; b < WIDTH; b++) begin : g_drv
        bufif1 u_buf (wBus[b], rd_s[b], iEn);
    end

endmodule

// File: tb/tb_gp_register_bank.sv
// Self-checking bench for gp_register_bank: directed scenarios plus a
// randomized run against an array-based reference model. The W buses are
// tri1 nets, so an undriven bus reads back as all ones.
module tb_gp_register_bank;
    import sap2_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default instance: WIDTH=8, NREGS=2
    logic [7:0] a_data = 8'h00;
    logic       a_wrsel = 1'b0, a_rdsel = 1'b0;
    logic       a_load = 1'b0, a_inc = 1'b0, a_dec = 1'b0, a_en = 1'b0;
    logic [7:0] a_odata;
    logic       a_zero, a_sign, a_err;
    tri1  [7:0] bus_a;

    // Small instance: WIDTH=4, NREGS=3 (index 3 is unbacked)
    logic [3:0] b_data = 4'h0;
    logic [1:0] b_wrsel = 2'd0, b_rdsel = 2'd0;
    logic       b_load = 1'b0, b_inc = 1'b0, b_dec = 1'b0, b_en = 1'b0;
    logic [3:0] b_odata;
    logic       b_zero, b_sign, b_err;
    tri1  [3:0] bus_b;

    gp_register_bank u_a (
        .iClk(clk), .iRst_n(rst_n), .iData(a_data), .iWrSel(a_wrsel),
        .iLoad(a_load), .iInc(a_inc), .iDec(a_dec), .iRdSel(a_rdsel), .iEn(a_en),
        .oData(a_odata), .oZero(a_zero), .oSign(a_sign), .oErr(a_err), .wBus(bus_a)
    );

    gp_register_bank #(.WIDTH(4), .NREGS(3)) u_b (
        .iClk(clk), .iRst_n(rst_n), .iData(b_data), .iWrSel(b_wrsel),
        .iLoad(b_load), .iInc(b_inc), .iDec(b_dec), .iRdSel(b_rdsel), .iEn(b_en),
        .oData(b_odata), .oZero(b_zero), .oSign(b_sign), .oErr(b_err), .wBus(bus_b)
    );

    int total = 0;
    int bad = 0;

    // Reference model of instance A
    logic [7:0] ma [2];
    logic       mz, ms, me;

    task automatic model_reset();
        ma[0] = 8'h00; ma[1] = 8'h00; mz = 1'b0; ms = 1'b0; me = 1'b0;
    endtask

    task automatic model_apply(input logic ld, input logic inc, input logic dec,
                               input logic sel, input logic [7:0] d);
        int v;
        if (ld) begin
            ma[sel] = d;
            me = inc | dec;
        end else if (inc && dec) begin
            me = 1'b1;
        end else if (inc || dec) begin
            v = (int'(ma[sel]) + (inc ? 1 : 255)) % 256;
            ma[sel] = v[7:0];
            mz = (v == 0);
            ms = (v >= 128);
            me = 1'b0;
        end else begin
            me = 1'b0;
        end
    endtask

    // One clock edge on instance A with the given command; returns 1 after the edge
    task automatic edge_a(input logic ld, input logic inc, input logic dec,
                          input logic sel, input logic [7:0] d);
        a_load = ld; a_inc = inc; a_dec = dec; a_wrsel = sel; a_data = d;
        @(posedge clk);
        model_apply(ld, inc, dec, sel, d);
        #1;
        a_load = 1'b0; a_inc = 1'b0; a_dec = 1'b0;
    endtask

    task automatic edge_b(input logic ld, input logic inc, input logic dec,
                          input logic [1:0] sel, input logic [3:0] d);
        b_load = ld; b_inc = inc; b_dec = dec; b_wrsel = sel; b_data = d;
        @(posedge clk);
        #1;
        b_load = 1'b0; b_inc = 1'b0; b_dec = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #12 rst_n = 1'b1;
        edge_a(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
        edge_a(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        edge_a(1'b1, 1'b0, 1'b0, 1'b1, 8'h42);
        edge_a(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        total++; if (a_err !== 1'b1 || a_zero !== 1'b1) begin bad++; $display("FAIL pre_reset: err=%b zero=%b want 1 1", a_err, a_zero); end
        a_load = 1'b1; a_data = 8'h77; a_en = 1'b0; a_rdsel = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (a_odata !== 8'h00) begin bad++; $display("FAIL reset_b: got %h want 00", a_odata); end
        total++; if ({a_zero, a_sign, a_err} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {a_zero, a_sign, a_err}); end
        total++; if (bus_a !== 8'hFF) begin bad++; $display("FAIL reset_bus_float: got %h want FF(pulled)", bus_a); end
        a_rdsel = 1'b1; #1;
        total++; if (a_odata !== 8'h00) begin bad++; $display("FAIL reset_c: got %h want 00", a_odata); end
        @(posedge clk); #1;
        total++; if (a_odata !== 8'h00 || a_err !== 1'b0) begin bad++; $display("FAIL reset_hold: data=%h err=%b want 00 0", a_odata, a_err); end
        a_load = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_load_drive();
        edge_a(1'b1, 1'b0, 1'b0, 1'(REG_B), 8'h3C);
        edge_a(1'b1, 1'b0, 1'b0, 1'(REG_C), 8'hA5);
        a_rdsel = 1'b1; a_en = 1'b1; #1;
        total++; if (bus_a !== 8'hA5) begin bad++; $display("FAIL drive_c: got %h want A5", bus_a); end
        total++; if (a_odata !== 8'hA5) begin bad++; $display("FAIL odata_c: got %h want A5", a_odata); end
        a_rdsel = 1'b0; #1;
        total++; if (bus_a !== 8'h3C) begin bad++; $display("FAIL drive_b: got %h want 3C", bus_a); end
        a_en = 1'b0; #1;
        total++; if (bus_a !== 8'hFF) begin bad++; $display("FAIL release_bus: got %h want FF(pulled)", bus_a); end
        total++; if ({a_zero, a_sign} !== 2'b00) begin bad++; $display("FAIL load_flags: got %b want 00", {a_zero, a_sign}); end
    endtask

    task automatic test_wrap();
        a_rdsel = 1'b1;
        edge_a(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF);
        edge_a(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        total++; if ({a_odata, a_zero, a_sign} !== {8'h00, 1'b1, 1'b0}) begin bad++; $display("FAIL inr_wrap: got %h z=%b s=%b want 00 1 0", a_odata, a_zero, a_sign); end
        edge_a(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        total++; if ({a_odata, a_zero, a_sign} !== {8'hFF, 1'b0, 1'b1}) begin bad++; $display("FAIL dcr_wrap: got %h z=%b s=%b want FF 0 1", a_odata, a_zero, a_sign); end
    endtask

    task automatic test_conflict();
        a_rdsel = 1'b0;
        edge_a(1'b1, 1'b0, 1'b0, 1'b0, 8'h10);
        edge_a(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        total++; if (a_odata !== 8'h10 || a_err !== 1'b1) begin bad++; $display("FAIL incdec: data=%h err=%b want 10 1", a_odata, a_err); end
        total++; if ({a_zero, a_sign} !== 2'b01) begin bad++; $display("FAIL incdec_flags: got %b want 01", {a_zero, a_sign}); end
        edge_a(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", a_err); end
        edge_a(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
        total++; if (a_odata !== 8'h77 || a_err !== 1'b1) begin bad++; $display("FAIL load_inc: data=%h err=%b want 77 1", a_odata, a_err); end
        total++; if ({a_zero, a_sign} !== 2'b01) begin bad++; $display("FAIL load_inc_flags: got %b want 01", {a_zero, a_sign}); end
    endtask

    task automatic test_rdw();
        edge_a(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
        a_rdsel = 1'b0; a_wrsel = 1'b0; a_load = 1'b1; a_data = 8'h55;
        #1;
        total++; if (a_odata !== 8'h3C) begin bad++; $display("FAIL rdw_before: got %h want 3C", a_odata); end
        @(posedge clk);
        model_apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
        #1;
        a_load = 1'b0;
        total++; if (a_odata !== 8'h55) begin bad++; $display("FAIL rdw_after: got %h want 55", a_odata); end
    endtask

    task automatic test_random();
        logic ld, inc, dec, sel;
        logic [7:0] d, want_bus;
        for (int n = 0; n < 300; n++) begin
            ld  = ($urandom_range(0, 3) == 0);
            inc = ($urandom_range(0, 2) == 0);
            dec = ($urandom_range(0, 2) == 0);
            sel = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            edge_a(ld, inc, dec, sel, d);
            a_rdsel = 1'($urandom_range(0, 1));
            a_en    = 1'($urandom_range(0, 1));
            #1;
            want_bus = a_en ? ma[a_rdsel] : 8'hFF;
            total++; if (a_odata !== ma[a_rdsel]) begin bad++; $display("FAIL rnd_data[%0d]: got %h want %h", n, a_odata, ma[a_rdsel]); end
            total++; if ({a_zero, a_sign, a_err} !== {mz, ms, me}) begin bad++; $display("FAIL rnd_flags[%0d]: got %b want %b", n, {a_zero, a_sign, a_err}, {mz, ms, me}); end
            total++; if (bus_a !== want_bus) begin bad++; $display("FAIL rnd_bus[%0d]: got %h want %h", n, bus_a, want_bus); end
        end
        a_en = 1'b0;
    endtask

    task automatic test_small();
        edge_b(1'b1, 1'b0, 1'b0, 2'd0, 4'h3);
        edge_b(1'b1, 1'b0, 1'b0, 2'd1, 4'hA);
        edge_b(1'b1, 1'b0, 1'b0, 2'd2, 4'hF);
        edge_b(1'b1, 1'b0, 1'b0, 2'd3, 4'h5);
        total++; if (b_err !== 1'b1) begin bad++; $display("FAIL small_badsel_err: got %b want 1", b_err); end
        b_rdsel = 2'd0; #1;
        total++; if (b_odata !== 4'h3) begin bad++; $display("FAIL small_r0: got %h want 3", b_odata); end
        b_rdsel = 2'd1; #1;
        total++; if (b_odata !== 4'hA) begin bad++; $display("FAIL small_r1: got %h want A", b_odata); end
        b_rdsel = 2'd2; #1;
        total++; if (b_odata !== 4'hF) begin bad++; $display("FAIL small_r2: got %h want F", b_odata); end
        b_rdsel = 2'd3; b_en = 1'b1; #1;
        total++; if (b_odata !== 4'h0 || bus_b !== 4'h0) begin bad++; $display("FAIL small_rd3: data=%h bus=%h want 0 0", b_odata, bus_b); end
        b_en = 1'b0; b_rdsel = 2'd2;
        edge_b(1'b0, 1'b1, 1'b0, 2'd2, 4'h0);
        total++; if ({b_odata, b_zero, b_sign, b_err} !== {4'h0, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL small_inr: got %h %b%b%b want 0 100", b_odata, b_zero, b_sign, b_err); end
        edge_b(1'b0, 1'b1, 1'b0, 2'd3, 4'h0);
        total++; if ({b_zero, b_sign, b_err} !== 3'b101) begin bad++; $display("FAIL small_inc_badsel: got %b want 101", {b_zero, b_sign, b_err}); end
        b_rdsel = 2'd1;
        edge_b(1'b0, 1'b0, 1'b1, 2'd1, 4'h0);
        total++; if ({b_odata, b_zero, b_sign, b_err} !== {4'h9, 1'b0, 1'b1, 1'b0}) begin bad++; $display("FAIL small_dcr: got %h %b%b%b want 9 010", b_odata, b_zero, b_sign, b_err); end
    endtask

    initial begin
        test_reset();
        test_load_drive();
        test_wrap();
        test_conflict();
        test_rdw();
        test_random();
        test_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
